// File: rtl/fp_add_share_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP32 adder driver
// between NREQ requesters, with a watchdog on the adder's done pulse.
module fp_add_share_arbiter #(
  parameter int NREQ    = 2,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64,
  localparam int REQ_W  = (NREQ <= 1) ? 1 : $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_z,
  output logic                   add_start,
  output logic [DATA_W-1:0]      add_a,
  output logic [DATA_W-1:0]      add_b,
  input  logic                   add_busy,
  input  logic                   add_done,
  input  logic [DATA_W-1:0]      add_z,
  output logic [REQ_W-1:0]       grant_id,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] QNAN = DATA_W'(32'h7FC0_0000);
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_RESP
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [REQ_W-1:0]  rr_ptr;
  logic [REQ_W-1:0]  win;
  logic              found;
  logic [WD_W-1:0]   wdog;
  logic [DATA_W-1:0] win_a;
  logic [DATA_W-1:0] win_b;
  logic              wd_hit;

  // Search starts just after the last owner, wrapping modulo NREQ.
  always_comb begin : p_win
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = REQ_W'(idx);
      end
    end
  end

  assign win_a  = req_a[DATA_W*int'(win) +: DATA_W];
  assign win_b  = req_b[DATA_W*int'(win) +: DATA_W];
  assign wd_hit = (wdog == WD_LIM);
  assign busy   = (state != S_IDLE);

  always_comb begin
    state_nx  = state;
    req_ready = '0;
    rsp_valid = '0;
    add_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (found) begin
          req_ready[win] = 1'b1;
          state_nx       = S_START;
        end
      end
      S_START: begin
        if (!add_busy) begin
          add_start = 1'b1;
          state_nx  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (add_done || wd_hit) state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid[grant_id] = 1'b1;
        state_nx            = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= REQ_W'(NREQ - 1);
      grant_id    <= '0;
      add_a       <= '0;
      add_b       <= '0;
      rsp_z       <= '0;
      timeout_err <= 1'b0;
      wdog        <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        S_IDLE: begin
          if (found) begin
            add_a    <= win_a;
            add_b    <= win_b;
            grant_id <= win;
            rr_ptr   <= win;
          end
        end
        S_START: begin
          if (!add_busy) wdog <= '0;
        end
        S_WAIT: begin
          // A done pulse on the limit cycle still counts as success.
          if (add_done) begin
            rsp_z <= add_z;
          end else if (wd_hit) begin
            rsp_z       <= QNAN;
            timeout_err <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_share_arbiter.sv
// Scoreboard bench for fp_add_share_arbiter: random requesters,
// behavioural FP32 adder, queue-based expected responses.
module tb_fp_add_share_arbiter;

  localparam int NREQ = 2;
  localparam int DW   = 32;
  localparam int TO   = 64;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic            clk;
  logic            rst;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0] req_ready;
  logic [NREQ-1:0] rsp_valid;
  logic [DW-1:0]   rsp_z;
  logic            add_start;
  logic [DW-1:0]   add_a;
  logic [DW-1:0]   add_b;
  logic            add_busy;
  logic            add_done;
  logic [DW-1:0]   add_z;
  logic [0:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  fp_add_share_arbiter #(
    .NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_z(rsp_z),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_busy(add_busy), .add_done(add_done), .add_z(add_z),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  typedef struct {
    int          id;
    logic [31:0] z;
    longint      due;
  } exp_t;

  exp_t    sb[$];
  int      grants[$];
  int      n_cmp;
  int      n_bad;
  int      n_start;
  int      last;
  int      lat;
  int      stall;
  int      rate;
  bit      hang;
  longint  cyc;
  longint  acc_cyc;
  logic [NREQ-1:0] acc_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] r2f(real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'h0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic real f2r(logic [31:0] f);
    logic [10:0] e;
    if (f[30:0] == 31'h0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] fsum(logic [31:0] a,
                                       logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  function automatic int pick(logic [NREQ-1:0] v, int lg);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(lg + k) % NREQ]) return (lg + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check(string nm, longint act, longint req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h @%0d", nm, act, req, cyc);
    end
  endtask

  task automatic fail_now(string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @%0d", nm, cyc);
  endtask

  // Monitor: accepts push expectations, responses pop and compare.
  always @(negedge clk) begin
    logic [NREQ-1:0] acc;
    int w;
    exp_t e;
    if (rst) begin
      acc_q = '0;
    end else begin
      acc   = req_valid & req_ready;
      acc_q = acc;
      if (req_ready != '0) begin
        check("ready_onehot", $countones(req_ready), 1);
        check("ready_wo_valid", req_ready & ~req_valid, 0);
        w = pick(req_valid, last);
        check("rr_winner", req_ready, NREQ'(1) << w);
        last = w;
        grants.push_back(w);
        acc_cyc = cyc;
        e.id  = w;
        e.z   = hang ? QNAN
                     : fsum(req_a[w*DW +: DW], req_b[w*DW +: DW]);
        e.due = cyc + 3 + (hang ? TO - 1 : lat) + stall;
        sb.push_back(e);
      end
      if (add_start) begin
        n_start++;
        check("start_while_busy", add_busy, 0);
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_rsp");
        end else begin
          e = sb.pop_front();
          check("rsp_owner", rsp_valid, NREQ'(1) << e.id);
          check("rsp_z", rsp_z, e.z);
          check("rsp_latency", cyc, e.due);
          check("grant_id", grant_id, e.id);
        end
      end
    end
  end

  // Behavioural adder: registers start, then L cycles to done.
  initial begin
    int l;
    logic [31:0] z;
    forever begin
      @(negedge clk);
      if (!rst && add_start === 1'b1 && !hang) begin
        l = lat;
        z = fsum(add_a, add_b);
        repeat (l + 1) @(posedge clk);
        #1;
        add_z    = z;
        add_done = 1'b1;
        @(posedge clk);
        #1 add_done = 1'b0;
      end
    end
  end

  task automatic set_req(int i, logic [31:0] a, logic [31:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
    req_valid[i]      = 1'b1;
  endtask

  task automatic new_req(int i);
    set_req(i, r2f(real'($urandom_range(1000))),
               r2f(real'($urandom_range(1000))));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_q[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && $urandom_range(99) < rate) new_req(i);
    end
  endtask

  task automatic drain(int lim);
    int n;
    n = 0;
    while ((sb.size() != 0 || req_valid != '0 || busy) && n < lim) begin
      step();
      n++;
    end
    if (n >= lim) fail_now("drain_bound");
    repeat (2) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    last = NREQ - 1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_time_bound");
    $fatal(1);
  end

  initial begin
    longint rel;
    int s0;
    n_cmp = 0; n_bad = 0; n_start = 0; cyc = 0; acc_cyc = -1;
    last = NREQ - 1; lat = 5; stall = 0; rate = 0; hang = 1'b0;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0;
    add_busy = 1'b0; add_done = 1'b0; add_z = '0; acc_q = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_z", rsp_z, 0);
    check("rst_add_start", add_start, 0);
    check("rst_add_ab", {add_a, add_b}, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_timeout", timeout_err, 0);

    // Single request right out of reset
    set_req(0, 32'h3F80_0000, 32'h4000_0000);
    rst = 1'b0;
    rel = cyc;
    drain(50);
    check("first_accept_cycle", acc_cyc, rel);
    check("single_sum_hold", rsp_z, 32'h4040_0000);

    // Simultaneous requests from reset
    do_reset();
    grants.delete();
    set_req(0, 32'h3F80_0000, 32'h4000_0000);
    set_req(1, 32'h4000_0000, 32'h4040_0000);
    drain(60);
    check("simul_cnt", grants.size(), 2);
    check("simul_g0", grants[0], 0);
    check("simul_g1", grants[1], 1);
    check("simul_last_z", rsp_z, 32'h40A0_0000);

    // Sustained contention
    grants.delete();
    rate = 100;
    for (int n = 0; n < 200 && grants.size() < 6; n++) step();
    rate = 0;
    drain(100);
    for (int k = 0; k < 6; k++) check("rotate", grants[k], k % 2);

    // Busy stall of 4 cycles at start
    s0 = n_start;
    add_busy = 1'b1;
    stall = 4;
    set_req(1, r2f(7.0), r2f(9.0));
    repeat (5) step();
    add_busy = 1'b0;
    stall = 0;
    drain(50);
    check("stall_starts", n_start - s0, 1);

    // done on the last watchdog cycle wins
    lat = TO - 1;
    set_req(0, r2f(11.0), r2f(12.0));
    drain(200);
    check("limit_done_no_err", timeout_err, 0);

    // Adder hangs: watchdog returns qNaN
    hang = 1'b1;
    set_req(1, r2f(1.0), r2f(1.0));
    drain(200);
    hang = 1'b0;
    check("wdog_err", timeout_err, 1);
    lat = 3;
    set_req(0, r2f(4.0), r2f(5.0));
    drain(50);
    check("wdog_sticky", timeout_err, 1);
    check("post_wdog_z", rsp_z, 32'h4110_0000);

    // Random traffic at several latencies
    for (int p = 0; p < 4; p++) begin
      lat  = $urandom_range(1, 8);
      rate = 30;
      repeat (150) step();
      rate = 0;
      drain(200);
    end

    // Async reset while waiting on the adder
    lat = 30;
    set_req(1, r2f(3.0), r2f(3.0));
    repeat (6) step();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_rsp", rsp_valid, 0);
    check("arst_start", add_start, 0);
    check("arst_grant", grant_id, 0);
    check("arst_err", timeout_err, 0);
    check("arst_add_a", add_a, 0);
    sb.delete();
    last = NREQ - 1;
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (45) step();
    check("stale_done_idle", sb.size(), 0);
    grants.delete();
    lat = 2;
    set_req(0, r2f(6.0), r2f(2.0));
    set_req(1, r2f(5.0), r2f(2.0));
    drain(60);
    check("post_rst_first", grants[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
